// File: rtl/lsl_seq.sv
// rtl/lsl_seq.sv - sequential logical-shift-left unit, one bit per clock
//
// Purpose:
//   Accepts an operand and a shift amount through a valid/ready handshake,
//   shifts the operand left one bit per clock, then presents the result
//   together with carry-out and zero flags through a second handshake.
//   Trades latency for area on the ALU shift path.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in1          operand to shift (WIDTH bits)
//   n            unsigned shift amount (SHAMT_W bits)
//   start_valid  request valid
//   start_ready  unit can accept a request (IDLE only)
//   result       shifted value
//   carry        last bit shifted out of the MSB, 0 when n == 0
//   zero         result equals 0, meaningful only while result_valid
//   result_valid result/carry/zero valid (DONE)
//   result_ready consumer accepts the result
//   busy         high while shifting
module lsl_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in1,
  input  logic [SHAMT_W-1:0] n,
  input  logic               start_valid,
  output logic               start_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  // The counter must hold both WIDTH (the clamp value) and any value of n.
  localparam int CLOG_W = $clog2(WIDTH + 1);
  localparam int CNT_W  = (CLOG_W > SHAMT_W) ? CLOG_W : SHAMT_W;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             carry_q;
  logic             zero_q;

  logic [CNT_W-1:0] n_ext;
  logic [WIDTH-1:0] acc_shl;

  assign n_ext   = CNT_W'(n);
  assign acc_shl = {acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc     <= in1;
            carry_q <= 1'b0;
            // Amounts of WIDTH or more shift everything out: clamp the count.
            count   <= (n_ext > WIDTH_C) ? WIDTH_C : n_ext;
            if (n == '0) begin
              state  <= DONE;
              zero_q <= (in1 == '0);
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          carry_q <= acc[WIDTH-1];
          acc     <= acc_shl;
          count   <= count - ONE_C;
          // zero is registered on the final shift so it is ready with DONE.
          if (count == ONE_C) begin
            state  <= DONE;
            zero_q <= (acc_shl == '0);
          end
        end
        DONE: begin
          if (result_ready) begin
            state  <= IDLE;
            zero_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state == SHIFT);
  assign result       = acc;
  assign carry        = carry_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_lsl_seq.sv
// tb/tb_lsl_seq.sv - directed self-checking bench for lsl_seq
module tb_lsl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1;
  logic [4:0]  n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  int total  = 0;
  int passed = 0;

  localparam logic [36:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

  lsl_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in1          (in1),
    .n            (n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .result       (result),
    .carry        (carry),
    .zero         (zero),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: one request from IDLE with result_ready=1, returning observations.
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh,
                        output logic [31:0] res, output logic cy, output logic zr,
                        output int lat, output int bc);
    in1 = a; n = sh; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1; bc = 0;
    while (!result_valid && lat < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    res = result; cy = carry; zr = zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [36:0] obs;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {start_ready, result_valid, busy, carry, zero, result};
    total++;
    if (obs !== RESET_VEC) $display("FAIL reset_hold: got %h want %h", obs, RESET_VEC);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {start_ready, result_valid, busy, carry, zero, result};
    total++;
    if (obs !== RESET_VEC) $display("FAIL reset_release: got %h want %h", obs, RESET_VEC);
    else passed++;
  endtask

  task automatic test_basic;
    logic [31:0] av [6];
    logic [4:0]  nv [6];
    logic [31:0] ev [6];
    logic [31:0] res;
    logic cy, zr;
    int lat, bc;
    av = '{32'd2, 32'd1, 32'd6, 32'd5, 32'd10, 32'd10};
    nv = '{5'd3, 5'd3, 5'd2, 5'd9, 5'd10, 5'd6};
    ev = '{32'd16, 32'd8, 32'd24, 32'd2560, 32'd10240, 32'd640};
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], nv[i], res, cy, zr, lat, bc);
      total++;
      if (res !== ev[i]) $display("FAIL basic[%0d] result: got %0d want %0d", i, res, ev[i]);
      else passed++;
      total++;
      if (cy !== 1'b0 || zr !== 1'b0) $display("FAIL basic[%0d] flags: got c=%b z=%b want c=0 z=0", i, cy, zr);
      else passed++;
      total++;
      if (lat != int'(nv[i]) + 1) $display("FAIL basic[%0d] latency: got %0d want %0d", i, lat, int'(nv[i]) + 1);
      else passed++;
      total++;
      if (bc != int'(nv[i])) $display("FAIL basic[%0d] busy_cycles: got %0d want %0d", i, bc, int'(nv[i]));
      else passed++;
    end
  endtask

  task automatic test_carry_zero;
    logic [31:0] av [3];
    logic [4:0]  nv [3];
    logic [31:0] ev [3];
    logic        ec [3];
    logic        ez [3];
    logic [31:0] res;
    logic cy, zr;
    int lat, bc;
    av = '{32'h8000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
    nv = '{5'd1, 5'd1, 5'd31};
    ev = '{32'h0000_0002, 32'h0000_0000, 32'h8000_0000};
    ec = '{1'b1, 1'b1, 1'b1};
    ez = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], nv[i], res, cy, zr, lat, bc);
      total++;
      if (res !== ev[i]) $display("FAIL cz[%0d] result: got %h want %h", i, res, ev[i]);
      else passed++;
      total++;
      if (cy !== ec[i]) $display("FAIL cz[%0d] carry: got %b want %b", i, cy, ec[i]);
      else passed++;
      total++;
      if (zr !== ez[i]) $display("FAIL cz[%0d] zero: got %b want %b", i, zr, ez[i]);
      else passed++;
      total++;
      if (lat != int'(nv[i]) + 1) $display("FAIL cz[%0d] latency: got %0d want %0d", i, lat, int'(nv[i]) + 1);
      else passed++;
    end
  endtask

  task automatic test_zero_shift;
    logic [31:0] res;
    logic cy, zr;
    int lat, bc;
    run_op(32'h1234, 5'd0, res, cy, zr, lat, bc);
    total++;
    if (res !== 32'h1234) $display("FAIL zshift result: got %h want 00001234", res);
    else passed++;
    total++;
    if (cy !== 1'b0 || zr !== 1'b0) $display("FAIL zshift flags: got c=%b z=%b want c=0 z=0", cy, zr);
    else passed++;
    total++;
    if (lat != 1) $display("FAIL zshift latency: got %0d want 1", lat);
    else passed++;
    total++;
    if (bc != 0) $display("FAIL zshift busy_cycles: got %0d want 0", bc);
    else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    result_ready = 1'b0;
    in1 = 32'd3; n = 5'd4; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 5) $display("FAIL bp latency: got %0d want 5", lat);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (result !== 32'd48 || carry !== 1'b0 || zero !== 1'b0 || result_valid !== 1'b1 || start_ready !== 1'b0)
        $display("FAIL bp hold[%0d]: got r=%0d c=%b z=%b rv=%b sr=%b want r=48 c=0 z=0 rv=1 sr=0",
                 c, result, carry, zero, result_valid, start_ready);
      else passed++;
      // A request pulse while DONE must be ignored.
      if (c == 1) begin in1 = 32'd99; n = 5'd1; start_valid = 1'b1; end
      if (c == 2) start_valid = 1'b0;
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL bp release: got rv=%b sr=%b want rv=0 sr=1", result_valid, start_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL bp no_accept_in_done: got busy=%b rv=%b want busy=0 rv=0", busy, result_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [36:0] obs;
    logic [31:0] res;
    logic cy, zr;
    int lat, bc, rv;
    in1 = 32'd7; n = 5'd20; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) $display("FAIL rmid busy_before: got %b want 1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    obs = {start_ready, result_valid, busy, carry, zero, result};
    total++;
    if (obs !== RESET_VEC) $display("FAIL rmid reset_vals: got %h want %h", obs, RESET_VEC);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (result_valid) rv++;
    end
    total++;
    if (rv != 0) $display("FAIL rmid stray_result: got %0d valid cycles want 0", rv);
    else passed++;
    run_op(32'd1, 5'd2, res, cy, zr, lat, bc);
    total++;
    if (res !== 32'd4) $display("FAIL rmid after result: got %0d want 4", res);
    else passed++;
    total++;
    if (lat != 3) $display("FAIL rmid after latency: got %0d want 3", lat);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ra [3];
    logic [4:0]  rn [3];
    logic [31:0] re [3];
    int          acc_cyc [3];
    logic [31:0] got [$];
    int idx, cyc, viol;
    logic sr;
    ra = '{32'd1, 32'h0F, 32'hAB};
    rn = '{5'd1, 5'd4, 5'd0};
    re = '{32'd2, 32'hF0, 32'hAB};
    acc_cyc = '{0, 0, 0};
    idx = 0; cyc = 0; viol = 0;
    result_ready = 1'b1;
    in1 = ra[0]; n = rn[0]; start_valid = 1'b1;
    while ((idx < 3 || got.size() < 3) && cyc < 100) begin
      sr = start_ready;
      if ((busy || result_valid) && start_ready) viol++;
      if (result_valid) got.push_back(result);
      @(posedge clk); #1;
      cyc++;
      if (sr && start_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin in1 = ra[idx]; n = rn[idx]; end
        else start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    total++;
    if (got.size() != 3) $display("FAIL b2b count: got %0d results want 3", got.size());
    else passed++;
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got[i] !== re[i]) $display("FAIL b2b result[%0d]: got %h want %h", i, got[i], re[i]);
        else passed++;
      end
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] != 3) $display("FAIL b2b gap0: got %0d want 3", acc_cyc[1] - acc_cyc[0]);
    else passed++;
    total++;
    if (acc_cyc[2] - acc_cyc[1] != 6) $display("FAIL b2b gap1: got %0d want 6", acc_cyc[2] - acc_cyc[1]);
    else passed++;
    total++;
    if (viol != 0) $display("FAIL b2b ready_when_busy: got %0d cycles want 0", viol);
    else passed++;
  endtask

  initial begin
    rst_n        = 1'b0;
    in1          = '0;
    n            = '0;
    start_valid  = 1'b0;
    result_ready = 1'b1;
    test_reset();
    test_basic();
    test_carry_zero();
    test_zero_shift();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsl_seq.md
# lsl_seq

Sequential logical-shift-left unit for the ALU, complementing the combinational right shifter. It accepts one operand and a shift amount through a valid/ready handshake and shifts left one bit per clock. It presents the result with carry-out and zero flags through a second valid/ready handshake. It serves the ALU's shift path where area matters more than latency.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- SHAMT_W, 5, shift-amount width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in1  input  WIDTH  operand to shift
- n  input  SHAMT_W  shift amount, unsigned
- start_valid  input  1  operand/amount valid
- start_ready  output  1  unit can accept a request
- result  output  WIDTH  shifted value
- carry  output  1  last bit shifted out of the MSB; 0 when n=0
- zero  output  1  result equals 0
- result_valid  output  1  result/carry/zero valid
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in SHIFT state

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: acc<=in1, carry<=0, count<=min(n, WIDTH).
  - Next state is DONE if n==0, else SHIFT.
- SHIFT:
  - Each cycle: carry<=acc[WIDTH-1], acc<=acc<<1 (zero fill), count<=count-1.
  - When count==1 at the clock edge, the next state is DONE.
- DONE:
  - result_valid=1; result=acc; zero=(acc==0).
  - On result_valid&&result_ready: next state is IDLE.
  - Until accepted, result, carry and zero are held stable.
- n≥WIDTH (possible only when 2^SHAMT_W>WIDTH): the shift runs WIDTH cycles, result=0, carry=in1[0].
- start_ready=0 in SHIFT and DONE. Inputs in1 and n are ignored outside the accept cycle, and changing them mid-operation has no effect.
- There is no accept in the same cycle as a result handshake. start_ready rises the cycle after DONE exits.
- Reset, asynchronous and at any point including mid-SHIFT or in DONE with the result unconsumed:
  - state=IDLE; acc, carry and count cleared.
  - The in-flight operation is discarded and produces no result.

## Timing
Reset values, while rst_n=0 and after release until the first accept:
- start_ready=1
- result_valid=0
- result=0
- carry=0
- zero=0
- busy=0

result, carry and zero are driven from registers. zero is valid only while result_valid=1.

Latency, with acceptance at edge k:
- n=0: result_valid=1 in cycle k+1.
- n=m≥1: result_valid=1 in cycle k+m+1 (m SHIFT cycles, busy=1 for exactly m cycles).

Throughput is one operation per m+2 cycles minimum with result_ready held at 1 (accept, m shifts, DONE, then IDLE).

result_valid stays high indefinitely under result_ready=0, with outputs frozen.

## Test plan
- Basic shifts, with result_ready=1:
  - in1=2, n=3 -> result=16, carry=0, zero=0, result_valid 4 cycles after accept.
  - in1=1, n=3 -> result=8.
  - in1=6, n=2 -> result=24.
  - in1=5, n=9 -> result=2560.
  - in1=10, n=10 -> result=10240.
  - in1=10, n=6 -> result=640.
- Carry and zero:
  - in1=0x80000001, n=1 -> result=0x00000002, carry=1.
  - in1=0x80000000, n=1 -> result=0, carry=1, zero=1.
  - in1=0xFFFFFFFF, n=31 -> result=0x80000000, carry=1.
- Zero shift: in1=0x1234, n=0 -> result=0x1234, carry=0, result_valid the cycle after accept, busy never asserted.
- Backpressure:
  - in1=3, n=4, result_ready=0 for 5 cycles after result_valid -> result=48 held stable, start_ready=0 throughout.
  - Raising result_ready -> IDLE one cycle later.
  - A start_valid pulse driven during DONE is not accepted.
- Reset mid-operation: in1=7, n=20, rst_n low for 1 cycle at SHIFT cycle 5 -> all outputs return to reset values immediately and no result_valid follows. A new request in1=1, n=2 then gives result=4 normally.
- Back-to-back: three requests with start_valid held high -> each accepted only when start_ready=1, and results are delivered in order with correct values.
